// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter merging the CPU instruction and data ports onto one
// memory port. Each port may hold one pending request. Transactions are issued
// one at a time, and a watchdog completes a transaction that never receives
// memory_ready.
module mem_arbiter_rr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        bus_error
);

  // Counter is at least one bit wide so that a disabled watchdog still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic          TO_EN   = 1'(TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Port select encoding: 0 = instruction port, 1 = data port.
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pend_i, r_pend_d;
  req_t          r_buf_i, r_buf_d;
  logic          r_grant;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_mem_valid;
  req_t          r_mem;
  logic          r_to_pulse;
  logic          r_to_port;

  logic w_cand_i, w_cand_d, w_issue, w_gnt, w_done, w_timeout;
  logic w_clr_i, w_clr_d, w_pass_i, w_pass_d;
  req_t w_in_i, w_in_d, w_req_i, w_req_d, w_gnt_req;

  // A port that is already pending keeps its latched request; otherwise the
  // request seen on the inputs this cycle is a candidate too.
  assign w_in_i   = {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
  assign w_in_d   = {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
  assign w_cand_i = r_pend_i | imemory_valid;
  assign w_cand_d = r_pend_d | dmemory_valid;
  assign w_req_i  = r_pend_i ? r_buf_i : w_in_i;
  assign w_req_d  = r_pend_d ? r_buf_d : w_in_d;
  assign w_gnt_req = w_gnt ? w_req_d : w_req_i;

  // Next-state logic: grant selection in IDLE, completion or watchdog in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_gnt       = r_grant;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cand_i || w_cand_d) begin
          w_issue     = 1'b1;
          w_gnt       = (w_cand_i && w_cand_d) ? ~r_last : w_cand_d;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (memory_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_clr_i = (w_done | w_timeout) & ~r_grant;
  assign w_clr_d = (w_done | w_timeout) &  r_grant;

  // State, grant bookkeeping, watchdog counter and the issued request registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_mem_valid <= 1'b0;
      r_mem       <= '0;
      r_to_pulse  <= 1'b0;
      r_to_port   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_valid <= w_issue;
      r_to_pulse  <= w_timeout;
      r_to_port   <= r_grant;
      if (w_issue) begin
        r_grant <= w_gnt;
        r_last  <= w_gnt;
        r_mem   <= w_gnt_req;
        r_cnt   <= '0;
      end else if ((r_state == ST_WAIT) && !memory_ready && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Pending buffers: first request wins, but a set on the clearing edge is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_i <= 1'b0;
      r_pend_d <= 1'b0;
      r_buf_i  <= '0;
      r_buf_d  <= '0;
    end else begin
      if (imemory_valid && (!r_pend_i || w_clr_i)) begin
        r_pend_i <= 1'b1;
        r_buf_i  <= w_in_i;
      end else if (w_clr_i) begin
        r_pend_i <= 1'b0;
      end
      if (dmemory_valid && (!r_pend_d || w_clr_d)) begin
        r_pend_d <= 1'b1;
        r_buf_d  <= w_in_d;
      end else if (w_clr_d) begin
        r_pend_d <= 1'b0;
      end
    end
  end

  // Normal responses pass straight through; forced completions come from registers.
  assign w_pass_i = (r_state == ST_WAIT) & memory_ready & ~r_grant;
  assign w_pass_d = (r_state == ST_WAIT) & memory_ready &  r_grant;

  assign imemory_ready = w_pass_i | (r_to_pulse & ~r_to_port);
  assign dmemory_ready = w_pass_d | (r_to_pulse &  r_to_port);
  assign imemory_rdata = w_pass_i ? memory_rdata : 32'h0000_0000;
  assign dmemory_rdata = w_pass_d ? memory_rdata : 32'h0000_0000;
  assign bus_error     = r_to_pulse;

  assign memory_valid = r_mem_valid;
  assign memory_instr = r_mem.instr;
  assign memory_addr  = r_mem.addr;
  assign memory_wdata = r_mem.wdata;
  assign memory_wstrb = r_mem.wstrb;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_arbiter_rr;

  localparam int TO = 4;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imemory_valid = 1'b0, imemory_instr = 1'b0;
  logic [31:0] imemory_addr = 32'h0, imemory_wdata = 32'h0;
  logic [3:0]  imemory_wstrb = 4'h0;
  logic [31:0] imemory_rdata;
  logic        imemory_ready;
  logic        dmemory_valid = 1'b0, dmemory_instr = 1'b0;
  logic [31:0] dmemory_addr = 32'h0, dmemory_wdata = 32'h0;
  logic [3:0]  dmemory_wstrb = 4'h0;
  logic [31:0] dmemory_rdata;
  logic        dmemory_ready;
  logic        memory_valid, memory_instr;
  logic [31:0] memory_addr, memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata = 32'h0;
  logic        memory_ready = 1'b0;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  mem_arbiter_rr #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .imemory_valid(imemory_valid), .imemory_instr(imemory_instr),
    .imemory_addr(imemory_addr), .imemory_wdata(imemory_wdata),
    .imemory_wstrb(imemory_wstrb), .imemory_rdata(imemory_rdata),
    .imemory_ready(imemory_ready),
    .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr),
    .dmemory_addr(dmemory_addr), .dmemory_wdata(dmemory_wdata),
    .dmemory_wstrb(dmemory_wstrb), .dmemory_rdata(dmemory_rdata),
    .dmemory_ready(dmemory_ready),
    .memory_valid(memory_valid), .memory_instr(memory_instr),
    .memory_addr(memory_addr), .memory_wdata(memory_wdata),
    .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  // Transaction-level model: per-port pending requests, the one transaction in
  // flight (port and cycles spent waiting), and the round-robin memory.
  bit   m_pend [2];
  req_t m_buf  [2];
  int   m_busy;     // -1 none, 0 instruction port, 1 data port
  int   m_k;        // cycles already spent waiting on the current transaction
  int   m_last;
  bit   m_issued;   // memory_valid expected this cycle
  req_t m_out;
  bit   m_forced;   // watchdog completion expected this cycle
  int   m_fport;
  int   m_lat;      // random slave latency for the current transaction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_buf[0] = '0; m_buf[1] = '0;
    m_busy = -1; m_k = 0; m_last = 0;
    m_issued = 1'b0; m_out = '0; m_forced = 1'b0; m_fport = 0; m_lat = 0;
  endtask

  // Advance the model by one clock edge using the inputs held for this cycle.
  task automatic model_update();
    bit   clr [2];
    bit   v   [2];
    req_t in  [2];
    bit   nf, ni;
    clr[0] = 1'b0; clr[1] = 1'b0; nf = 1'b0; ni = 1'b0;
    v[0] = imemory_valid; v[1] = dmemory_valid;
    in[0] = {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
    in[1] = {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
    if (m_busy >= 0) begin
      if (memory_ready) begin
        clr[m_busy] = 1'b1; m_busy = -1;
      end else if (m_k == TO - 1) begin
        nf = 1'b1; m_fport = m_busy; clr[m_busy] = 1'b1; m_busy = -1;
      end else begin
        m_k++;
      end
    end else begin
      bit c0, c1;
      int g;
      c0 = m_pend[0] || v[0];
      c1 = m_pend[1] || v[1];
      if (c0 || c1) begin
        g = (c0 && c1) ? 1 - m_last : (c1 ? 1 : 0);
        m_out  = m_pend[g] ? m_buf[g] : in[g];
        m_busy = g; m_k = 0; m_last = g; ni = 1'b1;
        m_lat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      end
    end
    for (int x = 0; x < 2; x++) begin
      if (v[x] && (!m_pend[x] || clr[x])) begin
        m_pend[x] = 1'b1; m_buf[x] = in[x];
      end else if (clr[x]) begin
        m_pend[x] = 1'b0;
      end
    end
    m_forced = nf;
    m_issued = ni;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    logic        er0, er1, be;
    logic [31:0] rd0, rd1;
    #1;
    er0 = 1'b0; er1 = 1'b0; be = 1'b0; rd0 = 32'h0; rd1 = 32'h0;
    if (m_busy >= 0 && memory_ready) begin
      if (m_busy == 0) begin er0 = 1'b1; rd0 = memory_rdata; end
      else begin er1 = 1'b1; rd1 = memory_rdata; end
    end else if (m_forced) begin
      be = 1'b1;
      if (m_fport == 0) er0 = 1'b1; else er1 = 1'b1;
    end
    chk("memory_valid", 32'(memory_valid), 32'(m_issued));
    chk("memory_instr", 32'(memory_instr), 32'(m_out.instr));
    chk("memory_addr", memory_addr, m_out.addr);
    chk("memory_wdata", memory_wdata, m_out.wdata);
    chk("memory_wstrb", 32'(memory_wstrb), 32'(m_out.wstrb));
    chk("imemory_ready", 32'(imemory_ready), 32'(er0));
    chk("imemory_rdata", imemory_rdata, rd0);
    chk("dmemory_ready", 32'(dmemory_ready), 32'(er1));
    chk("dmemory_rdata", dmemory_rdata, rd1);
    chk("bus_error", 32'(bus_error), 32'(be));
  endtask

  task automatic neg();
    @(negedge clock);
    imemory_valid = 1'b0; imemory_instr = 1'b0; imemory_addr = 32'h0;
    imemory_wdata = 32'h0; imemory_wstrb = 4'h0;
    dmemory_valid = 1'b0; dmemory_instr = 1'b0; dmemory_addr = 32'h0;
    dmemory_wdata = 32'h0; dmemory_wstrb = 4'h0;
    memory_ready = 1'b0; memory_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_update();
  endtask

  task automatic idle_cycle();
    neg(); check_cycle(); step();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_mvalid"}, 32'(memory_valid), 32'h0);
    chk({tag, "_maddr"}, memory_addr, 32'h0);
    chk({tag, "_iready"}, 32'(imemory_ready), 32'h0);
    chk({tag, "_dready"}, 32'(dmemory_ready), 32'h0);
    chk({tag, "_berr"}, 32'(bus_error), 32'h0);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    all_zero("rst");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    all_zero("por");
    @(negedge clock);
    reset = 1'b0;

    // Single read: request at cycle 0, issue at 1, response at 3.
    neg(); imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0100;
    check_cycle(); step();
    neg(); check_cycle();
    chk("t1_mvalid", 32'(memory_valid), 32'h1);
    chk("t1_maddr", memory_addr, 32'h0000_0100);
    step();
    idle_cycle();
    neg(); memory_ready = 1'b1; memory_rdata = 32'hDEAD_BEEF; check_cycle();
    chk("t1_iready", 32'(imemory_ready), 32'h1);
    chk("t1_irdata", imemory_rdata, 32'hDEAD_BEEF);
    chk("t1_dready", 32'(dmemory_ready), 32'h0);
    step();
    idle_cycle();

    // Simultaneous requests right after reset: data port wins the first tie.
    neg(); do_reset();
    neg();
    imemory_valid = 1'b1; imemory_addr = 32'h0000_0010;
    dmemory_valid = 1'b1; dmemory_addr = 32'h0000_0020; dmemory_wdata = 32'h0000_0055; dmemory_wstrb = 4'hF;
    check_cycle(); step();
    neg(); check_cycle();
    chk("t2_mvalid_d", 32'(memory_valid), 32'h1);
    chk("t2_maddr_d", memory_addr, 32'h0000_0020);
    chk("t2_mwdata_d", memory_wdata, 32'h0000_0055);
    chk("t2_mwstrb_d", 32'(memory_wstrb), 32'hF);
    step();
    neg(); memory_ready = 1'b1; memory_rdata = 32'h1234_5678; check_cycle();
    chk("t2_dready", 32'(dmemory_ready), 32'h1);
    step();
    idle_cycle();
    neg(); memory_ready = 1'b1; check_cycle();
    chk("t2_mvalid_i", 32'(memory_valid), 32'h1);
    chk("t2_maddr_i", memory_addr, 32'h0000_0010);
    chk("t2_iready", 32'(imemory_ready), 32'h1);
    step();
    neg();
    imemory_valid = 1'b1; imemory_addr = 32'h0000_0030;
    dmemory_valid = 1'b1; dmemory_addr = 32'h0000_0040;
    check_cycle(); step();
    neg(); memory_ready = 1'b1; check_cycle();
    chk("t2_tie2_addr", memory_addr, 32'h0000_0040);
    step();
    idle_cycle();
    neg(); memory_ready = 1'b1; check_cycle(); step();
    idle_cycle();

    // Request during WAIT: data request latched and issued unchanged afterwards.
    neg(); imemory_valid = 1'b1; imemory_addr = 32'h0000_0200; check_cycle(); step();
    neg(); dmemory_valid = 1'b1; dmemory_addr = 32'h0000_0300; dmemory_wdata = 32'hCAFE_F00D; dmemory_wstrb = 4'h3;
    check_cycle(); step();
    neg(); memory_ready = 1'b1; check_cycle();
    chk("t3_iready", 32'(imemory_ready), 32'h1);
    step();
    idle_cycle();
    neg(); check_cycle();
    chk("t3_mvalid", 32'(memory_valid), 32'h1);
    chk("t3_maddr", memory_addr, 32'h0000_0300);
    chk("t3_mwdata", memory_wdata, 32'hCAFE_F00D);
    step();
    neg(); memory_ready = 1'b1; check_cycle(); step();

    // Watchdog: no response ever; forced completion 4 cycles after memory_valid.
    neg(); imemory_valid = 1'b1; imemory_addr = 32'hF000_0000; check_cycle(); step();
    for (int c = 0; c < 4; c++) begin
      neg(); check_cycle();
      chk("t4_no_ready_yet", 32'(imemory_ready), 32'h0);
      step();
    end
    neg(); memory_rdata = 32'hAAAA_AAAA; check_cycle();
    chk("t4_iready", 32'(imemory_ready), 32'h1);
    chk("t4_irdata", imemory_rdata, 32'h0);
    chk("t4_berr", 32'(bus_error), 32'h1);
    step();
    neg(); check_cycle();
    chk("t4_berr_once", 32'(bus_error), 32'h0);
    step();
    neg(); memory_ready = 1'b1; memory_rdata = 32'h5555_5555; check_cycle();
    chk("t4_late_i", 32'(imemory_ready), 32'h0);
    chk("t4_late_d", 32'(dmemory_ready), 32'h0);
    step();

    // Asynchronous reset in WAIT with the data port pending.
    neg(); imemory_valid = 1'b1; imemory_addr = 32'h0000_0400; check_cycle(); step();
    neg(); dmemory_valid = 1'b1; dmemory_addr = 32'h0000_0500; check_cycle(); step();
    neg(); check_cycle(); do_reset();
    neg(); imemory_valid = 1'b1; imemory_addr = 32'h0000_0600; check_cycle(); step();
    neg(); check_cycle();
    chk("t5_mvalid", 32'(memory_valid), 32'h1);
    chk("t5_maddr", memory_addr, 32'h0000_0600);
    step();
    neg(); memory_ready = 1'b1; check_cycle(); step();
    for (int c = 0; c < 3; c++) begin
      neg(); check_cycle();
      chk("t5_no_dropped", 32'(memory_valid), 32'h0);
      step();
    end

    // Back-to-back on the same port: new request on the response cycle.
    neg(); imemory_valid = 1'b1; imemory_addr = 32'h0000_0700; check_cycle(); step();
    neg(); memory_ready = 1'b1; imemory_valid = 1'b1; imemory_addr = 32'h0000_0704;
    check_cycle(); step();
    idle_cycle();
    neg(); check_cycle();
    chk("t6_mvalid", 32'(memory_valid), 32'h1);
    chk("t6_maddr", memory_addr, 32'h0000_0704);
    step();
    neg(); memory_ready = 1'b1; check_cycle(); step();

    // Randomized traffic with a random-latency slave and stray late responses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      neg();
      imemory_valid = ($urandom_range(0, 3) == 0);
      imemory_instr = 1'($urandom_range(0, 1));
      imemory_addr  = $urandom();
      imemory_wdata = $urandom();
      imemory_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dmemory_valid = ($urandom_range(0, 3) == 0);
      dmemory_instr = 1'($urandom_range(0, 1));
      dmemory_addr  = $urandom();
      dmemory_wdata = $urandom();
      dmemory_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      memory_rdata  = $urandom();
      memory_ready  = (m_busy >= 0) ? (m_k == m_lat) : ($urandom_range(0, 7) == 0);
      check_cycle();
      if (cyc == 1500) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
